// File: rtl/dp_ram_pipe.sv
// rtl/dp_ram_pipe.sv - true dual-port byte-enabled RAM with pipelined reads
module dp_ram_pipe #(
    parameter int NB_COL       = 4,
    parameter int COL_WIDTH    = 8,
    parameter int RAM_DEPTH    = 1024,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0,
    parameter int PRIORITY_B   = 1,
    parameter     INIT_FILE    = "",
    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
    localparam int DW = NB_COL * COL_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              a_en_i,
    input  logic [NB_COL-1:0] a_we_i,
    input  logic [AW-1:0]     a_addr_i,
    input  logic [DW-1:0]     a_wdata_i,
    output logic [DW-1:0]     a_rdata_o,
    output logic              a_rvalid_o,
    input  logic              b_en_i,
    input  logic [NB_COL-1:0] b_we_i,
    input  logic [AW-1:0]     b_addr_i,
    input  logic [DW-1:0]     b_wdata_i,
    output logic [DW-1:0]     b_rdata_o,
    output logic              b_rvalid_o,
    output logic              collision_o
);

    // One spare bit so the depth itself is representable for the range check.
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(RAM_DEPTH);

    logic [DW-1:0] mem [RAM_DEPTH];

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("dp_ram_pipe: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    // Power-up image: all zero.
    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) begin
            mem[i] = '0;
        end
    end

    // Replace the columns selected by we in old with the matching columns of wd.
    function automatic logic [DW-1:0] merge_cols(input logic [DW-1:0]     old,
                                                 input logic [NB_COL-1:0] we,
                                                 input logic [DW-1:0]     wd);
        logic [DW-1:0] res;
        res = old;
        for (int c = 0; c < NB_COL; c++) begin
            if (we[c]) begin
                res[c*COL_WIDTH +: COL_WIDTH] = wd[c*COL_WIDTH +: COL_WIDTH];
            end
        end
        return res;
    endfunction

    logic          a_wr, a_rd, a_in_range;
    logic          b_wr, b_rd, b_in_range;
    logic          same_addr;
    logic [DW-1:0] a_old, b_old;
    logic [DW-1:0] a_word, b_word;

    assign a_wr       = a_en_i & (|a_we_i);
    assign a_rd       = a_en_i & ~(|a_we_i);
    assign b_wr       = b_en_i & (|b_we_i);
    assign b_rd       = b_en_i & ~(|b_we_i);
    assign a_in_range = {1'b0, a_addr_i} < DEPTH_L;
    assign b_in_range = {1'b0, b_addr_i} < DEPTH_L;
    assign same_addr  = (a_addr_i == b_addr_i);

    // Array lookup plus optional forwarding of the other port's same-cycle write.
    always_comb begin
        a_old  = a_in_range ? mem[a_addr_i] : '0;
        b_old  = b_in_range ? mem[b_addr_i] : '0;
        a_word = a_old;
        b_word = b_old;
        if (RDW_MODE != 0) begin
            if (b_wr && b_in_range && same_addr) begin
                a_word = merge_cols(a_old, b_we_i, b_wdata_i);
            end
            if (a_wr && a_in_range && same_addr) begin
                b_word = merge_cols(b_old, a_we_i, a_wdata_i);
            end
        end
    end

    // Column writes; on a same-address overlap only the priority port writes the column.
    always @(posedge clk_i) begin
        for (int c = 0; c < NB_COL; c++) begin
            if (rst_ni && a_wr && a_in_range && a_we_i[c] &&
                !(b_wr && b_we_i[c] && same_addr && PRIORITY_B != 0)) begin
                mem[a_addr_i][c*COL_WIDTH +: COL_WIDTH] <= a_wdata_i[c*COL_WIDTH +: COL_WIDTH];
            end
            if (rst_ni && b_wr && b_in_range && b_we_i[c] &&
                !(a_wr && a_we_i[c] && same_addr && PRIORITY_B == 0)) begin
                mem[b_addr_i][c*COL_WIDTH +: COL_WIDTH] <= b_wdata_i[c*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    logic          a_s1_valid, b_s1_valid;
    logic [DW-1:0] a_s1_data, b_s1_data;

    // First read stage for port A; data only moves when a read is accepted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_s1_valid <= 1'b0;
            a_s1_data  <= '0;
        end else begin
            a_s1_valid <= a_rd;
            if (a_rd) begin
                a_s1_data <= a_word;
            end
        end
    end

    // First read stage for port B.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            b_s1_valid <= 1'b0;
            b_s1_data  <= '0;
        end else begin
            b_s1_valid <= b_rd;
            if (b_rd) begin
                b_s1_data <= b_word;
            end
        end
    end

    logic collision_q;

    // Flag a same-address double write whose column masks overlap.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= a_wr & b_wr & same_addr & (|(a_we_i & b_we_i));
        end
    end

    assign collision_o = collision_q;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic          a_s2_valid, b_s2_valid;
            logic [DW-1:0] a_s2_data, b_s2_data;

            // Extra output register; follows stage one only on valid cycles so rdata holds.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    a_s2_valid <= 1'b0;
                    a_s2_data  <= '0;
                    b_s2_valid <= 1'b0;
                    b_s2_data  <= '0;
                end else begin
                    a_s2_valid <= a_s1_valid;
                    b_s2_valid <= b_s1_valid;
                    if (a_s1_valid) begin
                        a_s2_data <= a_s1_data;
                    end
                    if (b_s1_valid) begin
                        b_s2_data <= b_s1_data;
                    end
                end
            end

            assign a_rdata_o  = a_s2_data;
            assign a_rvalid_o = a_s2_valid;
            assign b_rdata_o  = b_s2_data;
            assign b_rvalid_o = b_s2_valid;
        end else begin : g_lat1
            assign a_rdata_o  = a_s1_data;
            assign a_rvalid_o = a_s1_valid;
            assign b_rdata_o  = b_s1_data;
            assign b_rvalid_o = b_s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram_pipe.sv
// tb/tb_dp_ram_pipe.sv - directed bench for dp_ram_pipe in two configurations
module tb_dp_ram_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_en, b_en;
    logic [3:0]  a_we, b_we;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    // x0: latency 1, read-first, B priority, 1024 words
    logic [31:0] x0_a_rdata, x0_b_rdata;
    logic        x0_a_rvalid, x0_b_rvalid, x0_coll;
    // x1: latency 2, write-first, A priority, 100 words
    logic [31:0] x1_a_rdata, x1_b_rdata;
    logic        x1_a_rvalid, x1_b_rvalid, x1_coll;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dp_ram_pipe #(
        .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(1024), .READ_LATENCY(1),
        .RDW_MODE(0), .PRIORITY_B(1), .INIT_FILE("")
    ) u_x0 (
        .clk_i(clk), .rst_ni(rst_n),
        .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_rdata_o(x0_a_rdata), .a_rvalid_o(x0_a_rvalid),
        .b_en_i(b_en), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_rdata_o(x0_b_rdata), .b_rvalid_o(x0_b_rvalid),
        .collision_o(x0_coll)
    );

    dp_ram_pipe #(
        .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(100), .READ_LATENCY(2),
        .RDW_MODE(1), .PRIORITY_B(0), .INIT_FILE("")
    ) u_x1 (
        .clk_i(clk), .rst_ni(rst_n),
        .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr[6:0]), .a_wdata_i(a_wdata),
        .a_rdata_o(x1_a_rdata), .a_rvalid_o(x1_a_rvalid),
        .b_en_i(b_en), .b_we_i(b_we), .b_addr_i(b_addr[6:0]), .b_wdata_i(b_wdata),
        .b_rdata_o(x1_b_rdata), .b_rvalid_o(x1_b_rvalid),
        .collision_o(x1_coll)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_en = 1'b0; a_we = 4'h0;
        b_en = 1'b0; b_we = 4'h0;
    endtask

    task automatic wr_a(input logic [9:0] addr, input logic [3:0] we, input logic [31:0] data);
        a_en = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
    endtask

    task automatic rd_a(input logic [9:0] addr);
        a_en = 1'b1; a_we = 4'h0; a_addr = addr;
    endtask

    task automatic wr_b(input logic [9:0] addr, input logic [3:0] we, input logic [31:0] data);
        b_en = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
    endtask

    task automatic rd_b(input logic [9:0] addr);
        b_en = 1'b1; b_we = 4'h0; b_addr = addr;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        tick();
        tick();
        // a write attempted while in reset must be ignored
        wr_a(10'd8, 4'hF, 32'hFFFF_FFFF);
        tick();
        check("rst_x0_a_rvalid", 32'(x0_a_rvalid), 32'h0);
        check("rst_x0_a_rdata", x0_a_rdata, 32'h0);
        check("rst_x0_b_rvalid", 32'(x0_b_rvalid), 32'h0);
        check("rst_x0_coll", 32'(x0_coll), 32'h0);
        check("rst_x1_a_rvalid", 32'(x1_a_rvalid), 32'h0);
        check("rst_x1_b_rdata", x1_b_rdata, 32'h0);
        idle();
        rst_n = 1'b1;
        tick();

        // full-word write then read on port A
        wr_a(10'd5, 4'hF, 32'hDEAD_BEEF);
        tick();
        check("t1_write_no_rvalid", 32'(x0_a_rvalid), 32'h0);
        idle(); rd_a(10'd5);
        tick();
        check("t1_x0_a_rvalid", 32'(x0_a_rvalid), 32'h1);
        check("t1_x0_a_rdata", x0_a_rdata, 32'hDEAD_BEEF);
        check("t1_x0_b_rvalid", 32'(x0_b_rvalid), 32'h0);
        check("t1_x0_b_rdata", x0_b_rdata, 32'h0);
        check("t1_x1_not_yet", 32'(x1_a_rvalid), 32'h0);
        idle();
        tick();
        check("t1_x1_a_rvalid", 32'(x1_a_rvalid), 32'h1);
        check("t1_x1_a_rdata", x1_a_rdata, 32'hDEAD_BEEF);
        check("t1_x0_pulse_end", 32'(x0_a_rvalid), 32'h0);
        check("t1_x0_rdata_hold", x0_a_rdata, 32'hDEAD_BEEF);

        // byte enables on port B
        wr_a(10'd7, 4'hF, 32'h1122_3344);
        tick();
        idle(); wr_b(10'd7, 4'b0101, 32'hAABB_CCDD);
        tick();
        idle(); rd_b(10'd7);
        tick();
        check("t2_x0_b_rvalid", 32'(x0_b_rvalid), 32'h1);
        check("t2_x0_b_rdata", x0_b_rdata, 32'h11BB_33DD);
        idle();
        tick();
        check("t2_x1_b_rdata", x1_b_rdata, 32'h11BB_33DD);

        // cross-port read during write
        rd_a(10'd9); wr_b(10'd9, 4'hF, 32'hCAFE_F00D);
        tick();
        check("t3_x0_a_rvalid", 32'(x0_a_rvalid), 32'h1);
        check("t3_x0_read_first", x0_a_rdata, 32'h0);
        idle();
        tick();
        check("t3_x1_a_rvalid", 32'(x1_a_rvalid), 32'h1);
        check("t3_x1_write_first", x1_a_rdata, 32'hCAFE_F00D);

        // same-address double write with one overlapping column
        wr_a(10'd3, 4'b0011, 32'h0000_00AA); wr_b(10'd3, 4'b0110, 32'h0000_BB00);
        tick();
        check("t4_x0_coll", 32'(x0_coll), 32'h1);
        check("t4_x1_coll", 32'(x1_coll), 32'h1);
        idle();
        tick();
        check("t4_coll_pulse_end", 32'(x0_coll), 32'h0);
        // disjoint columns at the same address do not count as a collision
        wr_a(10'd4, 4'b0011, 32'h0000_1111); wr_b(10'd4, 4'b1100, 32'h2222_0000);
        tick();
        check("t4_no_overlap_coll", 32'(x0_coll), 32'h0);
        idle(); rd_a(10'd3);
        tick();
        check("t4_x0_prio_b", x0_a_rdata, 32'h0000_BBAA);
        idle(); rd_a(10'd4);
        tick();
        check("t4_x1_prio_a", x1_a_rdata, 32'h0000_00AA);
        check("t4_x0_disjoint", x0_a_rdata, 32'h2222_1111);
        idle();
        tick();

        // both ports read the same address
        rd_a(10'd5); rd_b(10'd5);
        tick();
        check("dual_x0_a", x0_a_rdata, 32'hDEAD_BEEF);
        check("dual_x0_b", x0_b_rdata, 32'hDEAD_BEEF);
        idle();
        tick();
        check("dual_x1_b", x1_b_rdata, 32'hDEAD_BEEF);

        // the write issued during reset left addr 8 untouched
        rd_a(10'd8);
        tick();
        check("rst_write_ignored", x0_a_rdata, 32'h0);
        idle();
        tick();

        // latency-2 pipeline interrupted by reset
        wr_a(10'd0, 4'hF, 32'h0000_0100);
        tick();
        wr_a(10'd1, 4'hF, 32'h0000_0101);
        tick();
        wr_a(10'd2, 4'hF, 32'h0000_0102);
        tick();
        rd_a(10'd0);
        tick();
        check("t5_x0_first", x0_a_rdata, 32'h0000_0100);
        check("t5_x1_idle", 32'(x1_a_rvalid), 32'h0);
        rd_a(10'd1);
        tick();
        check("t5_x1_v0", 32'(x1_a_rvalid), 32'h1);
        check("t5_x1_d0", x1_a_rdata, 32'h0000_0100);
        rd_a(10'd2);
        tick();
        check("t5_x1_v1", 32'(x1_a_rvalid), 32'h1);
        check("t5_x1_d1", x1_a_rdata, 32'h0000_0101);
        rd_a(10'd3);
        tick();
        check("t5_x1_v2", 32'(x1_a_rvalid), 32'h1);
        check("t5_x1_d2", x1_a_rdata, 32'h0000_0102);
        idle();
        rst_n = 1'b0;
        tick();
        check("t5_rst_x1_rvalid", 32'(x1_a_rvalid), 32'h0);
        check("t5_rst_x1_rdata", x1_a_rdata, 32'h0);
        check("t5_rst_x0_rdata", x0_a_rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        check("t5_drop_a", 32'(x1_a_rvalid), 32'h0);
        tick();
        check("t5_drop_b", 32'(x1_a_rvalid), 32'h0);
        // memory survives reset
        rd_a(10'd5);
        tick();
        check("t5_mem_kept_x0", x0_a_rdata, 32'hDEAD_BEEF);
        idle();
        tick();
        check("t5_mem_kept_x1", x1_a_rdata, 32'hDEAD_BEEF);

        // out-of-range address on the 100-word instance
        wr_a(10'd56, 4'hF, 32'h5656_5656);
        tick();
        rd_a(10'd56);
        tick();
        idle();
        tick();
        check("t6_x1_56_before", x1_a_rdata, 32'h5656_5656);
        wr_a(10'd120, 4'hF, 32'h1234_5678);
        tick();
        rd_a(10'd120);
        tick();
        check("t6_x0_120", x0_a_rdata, 32'h1234_5678);
        idle();
        tick();
        check("t6_x1_oor_rvalid", 32'(x1_a_rvalid), 32'h1);
        check("t6_x1_oor_rdata", x1_a_rdata, 32'h0);
        rd_a(10'd56);
        tick();
        idle();
        tick();
        check("t6_x1_56_after", x1_a_rdata, 32'h5656_5656);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
